// File: rtl/quad_decoder.sv
// Quadrature A/B/Z encoder interface: synchronise and glitch-filter the pins, decode
// x1/x2/x4 steps into a wrapping position counter with index capture and error tracking.
module quad_decoder #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             z_in,
    input  logic [1:0]       mode,
    input  logic             invert_dir,
    input  logic             z_clear_en,
    input  logic             clr,
    input  logic             preset_load,
    input  logic [CNT_W-1:0] preset_val,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic             direction,
    output logic             step_pulse,
    output logic             index_pulse,
    output logic [CNT_W-1:0] index_latch,
    output logic             err_illegal,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        MODE_X4  = 2'd0,
        MODE_X2  = 2'd1,
        MODE_X1  = 2'd2,
        MODE_X4B = 2'd3
    } mode_e;

    localparam int CH_A     = 2;
    localparam int CH_B     = 1;
    localparam int CH_Z     = 0;
    // Edge index (minus one) at which the filter history first holds only real samples.
    localparam int FILL_MAX = SYNC_STAGES + FILT_LEN - 1;
    localparam int FILL_W   = $clog2(FILL_MAX + 1);

    logic [2:0]                  raw;
    logic [2:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0][FILT_LEN-1:0]    hist_q, hist_d;
    logic [2:0]                  filt_q, filt_d;
    logic [2:0]                  qual_q, qual_d;
    logic [FILL_W-1:0]           fill_q, fill_d;
    logic                        hist_full;

    logic                        armed_q, armed_d;
    logic [1:0]                  prev_q;
    logic                        z_prev_q;
    logic [1:0]                  cur_ab, chg;
    logic                        legal, illegal, a_tog, seq_up, counted, step_up;
    logic                        index_evt, z_clr_hit;
    mode_e                       mode_s;

    logic [CNT_W-1:0]            count_q, count_d;
    logic [CNT_W-1:0]            index_latch_q, index_latch_d;
    logic                        direction_q, direction_d;
    logic                        step_pulse_q, step_pulse_d;
    logic                        index_pulse_q;
    logic                        err_illegal_q, err_illegal_d;
    logic [7:0]                  err_cnt_q, err_cnt_d;

    assign raw       = {a_in, b_in, z_in};
    assign hist_full = (fill_q == FILL_W'(FILL_MAX));

    always_comb begin
        // NOTE: every variable gets a default before any conditional update, so no path
        // leaves it unassigned and no latch is inferred.
        fill_d = hist_full ? fill_q : fill_q + FILL_W'(1);
        for (int c = 0; c < 3; c++) begin
            sync_d[c] = SYNC_STAGES'({sync_q[c], raw[c]});
            hist_d[c] = FILT_LEN'({hist_q[c], sync_q[c][SYNC_STAGES-1]});
            filt_d[c] = filt_q[c];
            qual_d[c] = qual_q[c];
            if (hist_full && ((&hist_d[c]) || !(|hist_d[c]))) begin
                filt_d[c] = hist_d[c][0];
                qual_d[c] = 1'b1;
            end
        end
    end

    assign mode_s    = mode_e'(mode);
    assign cur_ab    = filt_q[CH_A:CH_B];
    assign chg       = cur_ab ^ prev_q;
    assign armed_d   = armed_q | (qual_q[CH_A] & qual_q[CH_B]);
    assign illegal   = armed_q && (chg == 2'b11);
    assign legal     = armed_q && ((chg == 2'b10) || (chg == 2'b01));
    assign a_tog     = chg[1];
    // Up order is 00->10->11->01: an A edge is up when A!=B afterwards, a B edge when A==B.
    assign seq_up    = a_tog ? (cur_ab[1] ^ cur_ab[0]) : ~(cur_ab[1] ^ cur_ab[0]);
    assign step_up   = seq_up ^ invert_dir;
    assign index_evt = filt_q[CH_Z] & ~z_prev_q;
    assign z_clr_hit = index_evt & z_clear_en;

    always_comb begin
        counted = legal;
        case (mode_s)
            MODE_X2: counted = legal && a_tog;
            MODE_X1: counted = legal && a_tog && cur_ab[1];
            default: counted = legal;
        endcase
    end

    always_comb begin
        count_d       = count_q;
        index_latch_d = index_latch_q;
        direction_d   = direction_q;
        step_pulse_d  = 1'b0;
        err_illegal_d = err_illegal_q;
        err_cnt_d     = err_cnt_q;

        if (clr) begin
            count_d = '0;
        end else if (preset_load) begin
            count_d = preset_val;
        end else if (z_clr_hit) begin
            count_d = '0;
        end else if (counted) begin
            count_d      = step_up ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
            step_pulse_d = 1'b1;
        end

        if (counted) begin
            direction_d = step_up;
        end
        if (index_evt) begin
            index_latch_d = count_q;
        end

        if (illegal) begin
            err_illegal_d = 1'b1;
            if (err_clr) begin
                err_cnt_d = 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else if (err_clr) begin
            err_illegal_d = 1'b0;
            err_cnt_d     = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            hist_q        <= '0;
            filt_q        <= '0;
            qual_q        <= '0;
            fill_q        <= '0;
            armed_q       <= 1'b0;
            prev_q        <= 2'b00;
            z_prev_q      <= 1'b0;
            count_q       <= '0;
            index_latch_q <= '0;
            direction_q   <= 1'b0;
            step_pulse_q  <= 1'b0;
            index_pulse_q <= 1'b0;
            err_illegal_q <= 1'b0;
            err_cnt_q     <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values,
            // which is what lets the synchroniser and filter chains shift correctly.
            sync_q        <= sync_d;
            hist_q        <= hist_d;
            filt_q        <= filt_d;
            qual_q        <= qual_d;
            fill_q        <= fill_d;
            armed_q       <= armed_d;
            prev_q        <= cur_ab;
            z_prev_q      <= filt_q[CH_Z];
            count_q       <= count_d;
            index_latch_q <= index_latch_d;
            direction_q   <= direction_d;
            step_pulse_q  <= step_pulse_d;
            index_pulse_q <= index_evt;
            err_illegal_q <= err_illegal_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign count       = count_q;
    assign direction   = direction_q;
    assign step_pulse  = step_pulse_q;
    assign index_pulse = index_pulse_q;
    assign index_latch = index_latch_q;
    assign err_illegal = err_illegal_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: a quadrature stimulus model pushes expected
// count/direction/step into a scoreboard that is popped when each edge is decoded.
module tb_quad_decoder;

    localparam int CNT_W = 32;
    localparam int SS    = 2;
    localparam int FL    = 4;
    localparam int LAT   = SS + FL + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             a_in = 1'b1, b_in = 1'b1, z_in = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             invert_dir = 1'b0, z_clear_en = 1'b0, clr = 1'b0;
    logic             preset_load = 1'b0, err_clr = 1'b0;
    logic [CNT_W-1:0] preset_val = '0;
    logic [CNT_W-1:0] count, index_latch;
    logic             direction, step_pulse, index_pulse, err_illegal;
    logic [7:0]       err_cnt;

    always #4 clk = ~clk;

    quad_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(SS), .FILT_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .z_in(z_in),
        .mode(mode), .invert_dir(invert_dir), .z_clear_en(z_clear_en), .clr(clr),
        .preset_load(preset_load), .preset_val(preset_val), .err_clr(err_clr),
        .count(count), .direction(direction), .step_pulse(step_pulse),
        .index_pulse(index_pulse), .index_latch(index_latch),
        .err_illegal(err_illegal), .err_cnt(err_cnt)
    );

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             dir;
        logic             stp;
    } exp_t;

    exp_t             sb[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [1:0]       ab_q = 2'b11;
    logic [CNT_W-1:0] m_count = '0;
    logic             m_dir = 1'b0;
    logic [1:0]       cur_mode = 2'd0;
    logic             cur_inv = 1'b0;

    function automatic logic [1:0] next_ab(input logic [1:0] ab, input bit up);
        return up ? {~ab[0], ab[1]} : {ab[0], ~ab[1]};
    endfunction

    // Drives one legal quadrature edge and queues what the decoder must show for it.
    task automatic quad_drive(input bit up, input bit discard, input logic [CNT_W-1:0] forced);
        logic [1:0] nab;
        bit         cnt;
        bit         sgn;
        exp_t       e;
        nab = next_ab(ab_q, up);
        case (cur_mode)
            2'd1:    cnt = (nab[1] != ab_q[1]);
            2'd2:    cnt = (nab[1] && !ab_q[1]);
            default: cnt = 1'b1;
        endcase
        sgn = up ^ cur_inv;
        if (cnt) m_dir = sgn;
        if (discard) m_count = forced;
        else if (cnt) m_count = sgn ? m_count + CNT_W'(1) : m_count - CNT_W'(1);
        e.cnt = m_count;
        e.dir = m_dir;
        e.stp = cnt && !discard;
        sb.push_back(e);
        ab_q = nab;
        a_in = nab[1];
        b_in = nab[0];
    endtask

    task automatic wait_decode(input bit with_clr, input bit with_errclr);
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        clr     = with_clr;
        err_clr = with_errclr;
        @(posedge clk);
        @(negedge clk);
        clr     = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic load_preset(input logic [CNT_W-1:0] v);
        preset_val  = v;
        preset_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        preset_load = 1'b0;
        m_count     = v;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({count, direction, step_pulse, index_pulse, index_latch, err_illegal, err_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_state: count=%0d dir=%b step=%b idx=%b latch=%0d ill=%b ecnt=%0d, required all 0",
                     count, direction, step_pulse, index_pulse, index_latch, err_illegal, err_cnt);
        end
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 6; i++) begin
            @(negedge clk);
            n_vec++;
            if (step_pulse !== 1'b0 || count !== '0) begin
                n_err++;
                $display("FAIL arming cycle %0d: step=%b count=%0d, required step=0 count=0", i, step_pulse, count);
            end
        end
    endtask

    task automatic test_x4();
        logic [CNT_W-1:0] old;
        exp_t             e;
        for (int i = 0; i < 52; i++) begin
            old = m_count;
            quad_drive(i < 40, 1'b0, '0);
            repeat (LAT - 1) @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (count !== old || step_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL x4_latency edge %0d: count=%0d step=%b early, required count=%0d step=0",
                         i, count, step_pulse, old);
            end
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if ({count, direction, step_pulse} !== {e.cnt, e.dir, e.stp}) begin
                n_err++;
                $display("FAIL x4_step %0d: count=%0d dir=%b step=%b, required %0d %b %b",
                         i, count, direction, step_pulse, e.cnt, e.dir, e.stp);
            end
            if (i == 39 || i == 51) begin
                n_vec++;
                if (count !== CNT_W'(i == 39 ? 40 : 28) || direction !== (i == 39)) begin
                    n_err++;
                    $display("FAIL x4_total after %0d edges: count=%0d dir=%b, required %0d %b",
                             i + 1, count, direction, (i == 39 ? 40 : 28), (i == 39));
                end
            end
        end
    endtask

    task automatic test_modes();
        exp_t             e;
        logic [CNT_W-1:0] expv;
        for (int m = 1; m <= 2; m++) begin
            for (int inv = 0; inv < 2; inv++) begin
                mode       = 2'(m);
                cur_mode   = 2'(m);
                invert_dir = inv[0];
                cur_inv    = inv[0];
                clr        = 1'b1;
                @(posedge clk);
                @(negedge clk);
                clr     = 1'b0;
                m_count = '0;
                n_vec++;
                if (count !== '0) begin
                    n_err++;
                    $display("FAIL clr mode=%0d inv=%0d: count=%0d, required 0", m, inv, count);
                end
                for (int i = 0; i < 40; i++) begin
                    quad_drive(1'b1, 1'b0, '0);
                    wait_decode(1'b0, 1'b0);
                    e = sb.pop_front();
                    n_vec++;
                    if ({count, direction, step_pulse} !== {e.cnt, e.dir, e.stp}) begin
                        n_err++;
                        $display("FAIL mode%0d_inv%0d step %0d: count=%0d dir=%b step=%b, required %0d %b %b",
                                 m, inv, i, count, direction, step_pulse, e.cnt, e.dir, e.stp);
                    end
                end
                expv = CNT_W'(m == 1 ? 20 : 10);
                if (inv != 0) expv = '0 - expv;
                n_vec++;
                if (count !== expv) begin
                    n_err++;
                    $display("FAIL mode%0d_inv%0d total: count=%0d, required %0d", m, inv, count, expv);
                end
            end
        end
        mode       = 2'd0;
        cur_mode   = 2'd0;
        invert_dir = 1'b0;
        cur_inv    = 1'b0;
    endtask

    task automatic test_glitch();
        exp_t e;
        bit   saw_step;
        for (int ch = 0; ch < 2; ch++) begin
            e = '{m_count, m_dir, 1'b0};
            sb.push_back(e);
            if (ch == 0) a_in = ~ab_q[1];
            else         b_in = ~ab_q[0];
            repeat (FL - 1) @(posedge clk);
            @(negedge clk);
            a_in     = ab_q[1];
            b_in     = ab_q[0];
            saw_step = 1'b0;
            for (int i = 0; i < LAT + FL; i++) begin
                @(negedge clk);
                saw_step |= step_pulse;
            end
            e = sb.pop_front();
            n_vec++;
            if ({count, saw_step, err_illegal} !== {e.cnt, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL glitch ch%0d: count=%0d step_seen=%b ill=%b, required %0d 0 0",
                         ch, count, saw_step, err_illegal, e.cnt);
            end
        end
    endtask

    task automatic test_errors();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e = '{m_count, m_dir, 1'b0};
            sb.push_back(e);
            ab_q = ~ab_q;
            a_in = ab_q[1];
            b_in = ab_q[0];
            wait_decode(1'b0, k == 1);
            e = sb.pop_front();
            n_vec++;
            if ({count, step_pulse, err_illegal, err_cnt} !== {e.cnt, 1'b0, 1'b1, 8'd1}) begin
                n_err++;
                $display("FAIL illegal%0d: count=%0d step=%b ill=%b ecnt=%0d, required %0d 0 1 1",
                         k, count, step_pulse, err_illegal, err_cnt, e.cnt);
            end
        end
        err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_clr = 1'b0;
        n_vec++;
        if (err_illegal !== 1'b0 || err_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL err_clr: ill=%b ecnt=%0d, required 0 0", err_illegal, err_cnt);
        end
        for (int i = 0; i < 260; i++) begin
            ab_q = ~ab_q;
            a_in = ab_q[1];
            b_in = ab_q[0];
            repeat (FL + 1) @(posedge clk);
            @(negedge clk);
        end
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (err_cnt !== 8'd255 || err_illegal !== 1'b1 || count !== m_count) begin
            n_err++;
            $display("FAIL err_saturate: ecnt=%0d ill=%b count=%0d, required 255 1 %0d",
                     err_cnt, err_illegal, count, m_count);
        end
        err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_wrap();
        exp_t e;
        load_preset('1);
        n_vec++;
        if (count !== '1) begin
            n_err++;
            $display("FAIL preset: count=%h, required ffffffff", count);
        end
        for (int k = 0; k < 2; k++) begin
            quad_drive(k == 0, 1'b0, '0);
            wait_decode(1'b0, 1'b0);
            e = sb.pop_front();
            n_vec++;
            if ({count, direction, step_pulse} !== {e.cnt, e.dir, e.stp} ||
                count !== (k == 0 ? CNT_W'(0) : '1)) begin
                n_err++;
                $display("FAIL wrap%0d: count=%h dir=%b step=%b, required %h %b %b",
                         k, count, direction, step_pulse, e.cnt, e.dir, e.stp);
            end
        end
    endtask

    task automatic test_index();
        exp_t             e;
        logic [CNT_W-1:0] base;
        for (int k = 0; k < 3; k++) begin
            base       = CNT_W'(k == 2 ? 200 : 57);
            z_clear_en = (k != 2);
            load_preset(base);
            z_in = 1'b1;
            quad_drive(1'b1, k != 2, '0);
            wait_decode(k == 1, 1'b0);
            e = sb.pop_front();
            n_vec++;
            if ({count, direction, step_pulse} !== {e.cnt, e.dir, e.stp} ||
                index_pulse !== 1'b1 || index_latch !== base) begin
                n_err++;
                $display("FAIL index%0d: count=%0d dir=%b step=%b idx=%b latch=%0d, required %0d %b %b 1 %0d",
                         k, count, direction, step_pulse, index_pulse, index_latch, e.cnt, e.dir, e.stp, base);
            end
            @(negedge clk);
            n_vec++;
            if (index_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL index%0d_width: idx=%b one cycle later, required 0", k, index_pulse);
            end
            z_in = 1'b0;
            repeat (LAT + 2) @(posedge clk);
            @(negedge clk);
        end
        z_clear_en = 1'b0;
    endtask

    task automatic test_midreset();
        load_preset(CNT_W'(123));
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({count, direction, step_pulse, index_pulse, index_latch, err_illegal, err_cnt} !== '0) begin
            n_err++;
            $display("FAIL async_reset: count=%0d dir=%b latch=%0d, required all 0", count, direction, index_latch);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        m_count = '0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (step_pulse !== 1'b0 || count !== '0) begin
                n_err++;
                $display("FAIL rearm cycle %0d: step=%b count=%0d, required 0 0", i, step_pulse, count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_x4();
        test_modes();
        test_glitch();
        test_errors();
        test_wrap();
        test_index();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Parametrised quadrature encoder interface for the A/B/Z encoder inputs. It provides:
- per-input synchroniser and glitch filter,
- selectable x1/x2/x4 decoding,
- a CNT_W-bit wrapping position counter with preset and clear,
- index capture and optional clear on Z,
- illegal-transition detection.

It sits between the encoder pins and the motion/debug logic on the 125 MHz system clock.

## Interface
Parameters:
- CNT_W, 32: position counter width (>=8).
- SYNC_STAGES, 2: synchroniser flops per input (>=2).
- FILT_LEN, 4: consecutive equal synchronised samples required before a filtered level changes (>=1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- a_in, b_in, z_in  in  1 each  raw encoder channels; asynchronous to clk.
- mode  in  2  decode mode: 0 = x4, 1 = x2, 2 = x1, 3 = x4.
- invert_dir  in  1  negates the sign of every counted step.
- z_clear_en  in  1  clears the counter on an index event.
- clr  in  1  synchronous counter clear.
- preset_load  in  1  loads preset_val into the counter.
- preset_val  in  CNT_W  preset value.
- err_clr  in  1  clears err_illegal and err_cnt.
- count  out  CNT_W  position; reset value 0.
- direction  out  1  sign of the last counted step (1 = up); reset value 0.
- step_pulse  out  1  one-cycle strobe per counted step; reset value 0.
- index_pulse  out  1  one-cycle strobe on a filtered Z rising edge; reset value 0.
- index_latch  out  CNT_W  count value captured on an index event; reset value 0.
- err_illegal  out  1  sticky illegal-transition flag; reset value 0.
- err_cnt  out  8  saturating illegal-transition count; reset value 0.

## Operation
- **Synchroniser:** each raw input passes through SYNC_STAGES flops, all reset to 0.
- **Filter:** each channel keeps a shift history of its last FILT_LEN synchronised samples. The filtered level takes the new value only when all FILT_LEN samples are equal. Pulses shorter than FILT_LEN cycles never reach the decoder.
- **Arming:**
  - After reset, the decoder stays unarmed until the A and B filters have each observed FILT_LEN equal samples.
  - The first qualified {A,B} becomes the reference state. No step is counted at arming.
- **Decode:** each cycle the decoder compares the previous filtered state {A,B} with the current one.
  - Up sequence (A leads B): 00→10→11→01→00. Down is the reverse.
  - A state change in which A and B both toggle is illegal: no count, err_illegal set, err_cnt incremented (saturates at 255).
  - A state change in which only one channel toggles is legal. For that change:
    - x4: counts every legal change.
    - x2: counts only the A toggles.
    - x1: counts only the A rising edges; B=0 at that edge means up, B=1 means down.
- **Step effect:** step sign = up/down XOR invert_dir. count ± 1, modulo 2^CNT_W (wraps silently both ways). A counted step also updates direction and asserts step_pulse.
- **Index:**
  - A filtered Z 0→1 edge asserts index_pulse. Z needs no arming.
  - index_latch captures count as it stands before that cycle's update.
  - With z_clear_en=1, count becomes 0.
- **Counter update priority, same cycle:** clr > preset_load > index clear > step.
  - A step that loses to a higher-priority update is discarded.
  - step_pulse stays 0 for a discarded step; direction still updates.
- **err_clr:** zeroes err_illegal and err_cnt. An illegal transition in the same cycle wins: err_illegal=1, err_cnt=1.
- **mode:** sampled every cycle. A change takes effect on the next transition and never produces a step by itself.

## Timing
- Latency: from the first clk edge sampling a new a_in/b_in level to the update of count, direction and step_pulse is SYNC_STAGES + FILT_LEN + 1 cycles. The same latency applies from z_in to index_pulse and index_latch.
- clr, preset_load and err_clr act on the next clk edge with one-cycle latency; no synchroniser or filter.
- All outputs are registered. Strobes are exactly one cycle wide.
- Reset asserted mid-operation immediately forces every output and internal register to 0, including arming, filter histories and synchronisers. Re-arming follows reset release as described under Arming.
- Maximum countable edge rate: one legal transition per FILT_LEN+1 cycles per channel. Faster input is filtered, not miscounted.

## Test plan
- Reset with a_in=b_in=1, then release: the decoder arms after SYNC_STAGES+FILT_LEN cycles with count=0 and step_pulse never asserted.
- x4 mode, 10 full up cycles: count=40, direction=1. Then 3 down cycles: count=28, direction=0. Each edge shows latency SYNC_STAGES+FILT_LEN+1.
- x2 and x1 modes, 10 up cycles each from count=0: x2 gives count=20, x1 gives count=10. Repeat with invert_dir=1: the results are the negated values modulo 2^CNT_W, e.g. x1 gives 2^CNT_W-10.
- Glitch of FILT_LEN-1 cycles on a_in: no count change. Simultaneous toggle of A and B: count unchanged, err_illegal=1, err_cnt=1. Then err_clr: both 0.
- preset_val=2^CNT_W-1, then 1 up step: count=0 (wrap). Then 1 down step: count=2^CNT_W-1.
- z_clear_en=1 at count=57, Z pulse coinciding with an up step: index_pulse=1, index_latch=57, count=0, step_pulse=0. The same cycle with clr also asserted: count=0, index_latch=57.
